// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multi-cycle RISC-V datapath. A single ALU, memory
// port and register file are shared across FETCH/DECODE/EXEC/MEM/WB. Illegal
// opcodes and memory accesses that wait too long for mem_ready both trap.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_2_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Wait count at which a further cycle without mem_ready becomes a timeout.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  logic [6:0] op_q;
  logic [7:0] wait_cnt;
  logic [1:0] cause_q, cause_nxt;
  logic       retire, waiting, limit_hit;
  logic       ir_write_c, pc_write_c, pc_src_c, alu_src_c;
  logic       mem_read_c, mem_write_c, mem_2_reg_c, reg_write_c;
  logic [1:0] alu_op_c;

  assign limit_hit = (wait_cnt == WAIT_LIMIT);

  // Next-state, trap cause and per-state control strobes.
  always_comb begin
    nxt         = cur;
    cause_nxt   = cause_q;
    retire      = 1'b0;
    waiting     = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    alu_op_c    = 2'b10;
    alu_src_c   = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_2_reg_c = 1'b0;
    reg_write_c = 1'b0;
    unique case (cur)
      FETCH: begin
        // A nonzero wait count means the fetch already started, so a late
        // drop of enable must not abandon it.
        if (enable || (wait_cnt != '0)) begin
          mem_read_c = 1'b1;
          if (mem_ready) begin
            ir_write_c = 1'b1;
            nxt        = DECODE;
          end else begin
            waiting = 1'b1;
            if (limit_hit) begin
              nxt       = TRAP;
              cause_nxt = 2'b10;
            end
          end
        end
      end
      DECODE: begin
        unique case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL: nxt = EXEC;
          default: begin
            nxt       = TRAP;
            cause_nxt = 2'b01;
          end
        endcase
      end
      EXEC: begin
        unique case (op_q)
          OP_R: nxt = WB;
          OP_I: begin
            alu_op_c  = 2'b00;
            alu_src_c = 1'b1;
            nxt       = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op_c  = 2'b00;
            alu_src_c = 1'b1;
            nxt       = MEM;
          end
          OP_BEQ: begin
            alu_op_c   = 2'b01;
            pc_write_c = 1'b1;
            pc_src_c   = zero;
            retire     = 1'b1;
            nxt        = FETCH;
          end
          OP_JAL: begin
            pc_write_c = 1'b1;
            pc_src_c   = 1'b1;
            retire     = 1'b1;
            nxt        = FETCH;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        alu_op_c    = 2'b00;
        alu_src_c   = 1'b1;
        mem_read_c  = (op_q == OP_LOAD);
        mem_write_c = (op_q != OP_LOAD);
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            nxt = WB;
          end else begin
            pc_write_c = 1'b1;
            retire     = 1'b1;
            nxt        = FETCH;
          end
        end else begin
          waiting = 1'b1;
          if (limit_hit) begin
            nxt       = TRAP;
            cause_nxt = 2'b10;
          end
        end
      end
      WB: begin
        reg_write_c = 1'b1;
        mem_2_reg_c = (op_q == OP_LOAD);
        pc_write_c  = 1'b1;
        retire      = 1'b1;
        nxt         = FETCH;
      end
      TRAP: nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  // State, latched opcode, trap cause, wait counter and retire counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cur      <= FETCH;
      op_q     <= '0;
      cause_q  <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      cur     <= nxt;
      cause_q <= cause_nxt;
      if (cur == DECODE) op_q <= opcode;
      // Any cycle that is not a continuing wait leaves the counter at zero,
      // which covers the clear on entry to FETCH and to MEM.
      if (waiting) wait_cnt <= wait_cnt + 8'd1;
      else         wait_cnt <= '0;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Strobes are gated by reset so nothing leaks while arst_n is low.
  assign ir_write   = arst_n & ir_write_c;
  assign pc_write   = arst_n & pc_write_c;
  assign pc_src     = arst_n & pc_src_c;
  assign alu_op     = arst_n ? alu_op_c : 2'b10;
  assign alu_src    = arst_n & alu_src_c;
  assign mem_read   = arst_n & mem_read_c;
  assign mem_write  = arst_n & mem_write_c;
  assign mem_2_reg  = arst_n & mem_2_reg_c;
  assign reg_write  = arst_n & reg_write_c;
  assign trap       = (cur == TRAP);
  assign trap_cause = cause_q;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: hand-computed expected values
// checked with immediate assertions after each clock edge.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, pc_src, alu_src;
  logic        mem_read, mem_write, mem_2_reg, reg_write, trap;
  logic [1:0]  alu_op, trap_cause;
  logic [31:0] retired;
  logic [2:0]  state;

  logic        ir_write4, pc_write4, pc_src4, alu_src4;
  logic        mem_read4, mem_write4, mem_2_reg4, reg_write4, trap4;
  logic [1:0]  alu_op4, trap_cause4;
  logic [3:0]  retired4;
  logic [2:0]  state4;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_ret   = 0;
  int steps     = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_2_reg(mem_2_reg), .reg_write(reg_write), .trap(trap),
    .trap_cause(trap_cause), .retired(retired), .state(state)
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write4),
    .pc_write(pc_write4), .pc_src(pc_src4), .alu_op(alu_op4),
    .alu_src(alu_src4), .mem_read(mem_read4), .mem_write(mem_write4),
    .mem_2_reg(mem_2_reg4), .reg_write(reg_write4), .trap(trap4),
    .trap_cause(trap_cause4), .retired(retired4), .state(state4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    steps++;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {ir_write, pc_write, pc_src, alu_src, mem_read, mem_write, mem_2_reg, reg_write};
  endfunction

  task automatic do_reset();
    arst_n = 1'b0;
    #2;
    @(negedge clk);
    arst_n = 1'b1;
    exp_ret = 0;
    #1;
  endtask

  // Fetch with mem_ready on the first cycle, leaving the FSM in DECODE.
  task automatic fetch_fast(input logic [6:0] op);
    enable = 1'b1;
    opcode = op;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    // Reset: strobes held low even with enable/mem_ready high
    arst_n = 1'b0;
    enable = 1'b1;
    mem_ready = 1'b1;
    #12;
    chk("rst_state", state, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_retired", retired, 0);
    chk("rst_strobes", strobes(), 0);
    enable = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    #1;

    // R-type, ready on first fetch cycle: 0,1,2,4,0
    enable = 1'b1; opcode = OP_R; mem_ready = 1'b1;
    settle();
    chk("r_f_state", state, 0);
    chk("r_f_strobes", strobes(), 8'b1000_1000);
    step(); mem_ready = 1'b0; settle();
    chk("r_d_state", state, 1);
    chk("r_d_strobes", strobes(), 0);
    step();
    chk("r_e_state", state, 2);
    chk("r_e_aluop", alu_op, 2'b10);
    chk("r_e_strobes", strobes(), 0);
    enable = 1'b0;
    step();
    chk("r_wb_state", state, 4);
    chk("r_wb_strobes", strobes(), 8'b0100_0001);
    step(); exp_ret++;
    chk("r_end_state", state, 0);
    chk("r_retired", retired, exp_ret);
    chk("r_idle_mread", mem_read, 0);

    // LOAD: 3 wait cycles in FETCH, 2 in MEM; enable drops mid-fetch
    steps = 0;
    enable = 1'b1; opcode = OP_LOAD; mem_ready = 1'b0;
    settle();
    chk("ld_f0_mread", mem_read, 1);
    step(); enable = 1'b0; settle();
    chk("ld_f1_mread", mem_read, 1);
    chk("ld_f1_state", state, 0);
    step();
    chk("ld_f2_mread", mem_read, 1);
    step(); mem_ready = 1'b1; settle();
    chk("ld_f3_irw", {mem_read, ir_write}, 2'b11);
    step(); mem_ready = 1'b0; settle();
    chk("ld_d_state", state, 1);
    step();
    chk("ld_e_alu", {alu_op, alu_src}, 3'b001);
    chk("ld_e_state", state, 2);
    step();
    chk("ld_m0_state", state, 3);
    chk("ld_m0_strobes", strobes(), 8'b0001_1000);
    chk("ld_m0_aluop", alu_op, 2'b00);
    step();
    chk("ld_m1_mread", mem_read, 1);
    step(); mem_ready = 1'b1; settle();
    chk("ld_m2_mread", mem_read, 1);
    step(); mem_ready = 1'b0; settle();
    chk("ld_wb_state", state, 4);
    chk("ld_wb_strobes", strobes(), 8'b0100_0011);
    step(); exp_ret++;
    chk("ld_steps", steps, 10);
    chk("ld_end_state", state, 0);
    chk("ld_retired", retired, exp_ret);

    // BEQ taken then not taken
    zero = 1'b1;
    fetch_fast(OP_BEQ);
    step();
    chk("beq1_e_state", state, 2);
    chk("beq1_e_aluop", alu_op, 2'b01);
    chk("beq1_e_strobes", strobes(), 8'b0110_0000);
    step(); exp_ret++;
    chk("beq1_end_state", state, 0);
    zero = 1'b0;
    fetch_fast(OP_BEQ);
    step();
    chk("beq0_e_aluop", alu_op, 2'b01);
    chk("beq0_e_strobes", strobes(), 8'b0100_0000);
    step(); exp_ret++;
    chk("beq0_end_state", state, 0);
    chk("beq_retired", retired, exp_ret);

    // JAL and I-type
    fetch_fast(OP_JAL);
    step();
    chk("jal_e_strobes", strobes(), 8'b0110_0000);
    step(); exp_ret++;
    chk("jal_end_state", state, 0);
    fetch_fast(OP_I);
    step();
    chk("i_e_alu", {alu_op, alu_src}, 3'b001);
    step();
    chk("i_wb_strobes", strobes(), 8'b0100_0001);
    step(); exp_ret++;
    chk("i_retired", retired, exp_ret);

    // Illegal opcode traps and stays trapped
    fetch_fast(7'b1111111);
    chk("ill_d_state", state, 1);
    step();
    chk("ill_state", state, 5);
    chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 2'b01);
    chk("ill_strobes", strobes(), 0);
    enable = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ill_hold_state", state, 5);
    end
    chk("ill_hold_cause", trap_cause, 2'b01);
    chk("ill_hold_retired", retired, exp_ret);
    mem_ready = 1'b0; enable = 1'b0;
    do_reset();
    chk("ill_rst_state", state, 0);
    chk("ill_rst_trap", {trap, trap_cause}, 0);

    // STORE with no mem_ready: 15 cycles of mem_write then timeout trap
    fetch_fast(OP_STORE);
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      chk("st_to_mwrite", {state, mem_write}, {3'd3, 1'b1});
      step();
    end
    chk("st_to_state", state, 5);
    chk("st_to_cause", trap_cause, 2'b10);
    chk("st_to_strobes", strobes(), 0);
    enable = 1'b0;
    do_reset();

    // STORE with mem_ready on the 15th MEM cycle completes
    fetch_fast(OP_STORE);
    step();
    step();
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1; settle();
    chk("st_ok_state", state, 3);
    chk("st_ok_strobes", strobes(), 8'b0101_0100);
    step(); mem_ready = 1'b0; exp_ret++; settle();
    chk("st_ok_end_state", state, 0);
    chk("st_ok_retired", retired, exp_ret);
    chk("st_ok_trap", trap, 0);

    // Idle: enable=0 ignores mem_ready
    enable = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_state_mread", {state, mem_read}, {3'd0, 1'b0});
    end
    mem_ready = 1'b0;

    // Reset during a pending fetch drops mem_read at once
    enable = 1'b1;
    step();
    chk("mid_pending_mread", mem_read, 1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_mread", mem_read, 0);
    enable = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    exp_ret = 0;
    step();
    chk("mid_after_mread", {state, mem_read}, {3'd0, 1'b0});

    // 17 R-types: 32-bit counter reads 17, 4-bit counter wraps to 1
    do_reset();
    for (int n = 0; n < 17; n++) begin
      fetch_fast(OP_R);
      step();
      step();
      step();
      exp_ret++;
    end
    chk("wrap_retired32", retired, exp_ret);
    chk("wrap_retired4", retired4, 4'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
